// File: rtl/sram_pin_responder.sv
// ---------------------------------------------------------------------------
// sram_pin_responder
//
// Emulates an external asynchronous 16-bit SRAM behind the controller's pin
// interface, using on-chip block RAM. Every pin is brought into the clk_in
// domain through a synchronizer chain. Writes are committed on the trailing
// edge of the write strobe. Read data is driven while output-enable is held.
//
// Pin protocol (as seen after synchronization):
//   A cycle is a write while ce_n=0 and we_n=0. The write is committed with
//   the last address/data/lane values seen while the strobe was low.
//   A cycle is a read while ce_n=0, oe_n=0 and we_n=1. Data is driven while
//   the read stays asserted, and it is refetched whenever the address
//   changes.
//   A write takes priority over a read. The responder never drives dq while
//   the sampled we_n is low.
//
// Parameters
//   DEPTH_W      implemented word-address bits (must be < 18)
//   SYNC_STAGES  synchronizer depth on every pin input (must be >= 2)
//
// Ports
//   clk_in          sampling clock, at least 4x the controller clock
//   rst_in          asynchronous, active-low reset
//   sram_ce_n_in    chip enable (active-low)
//   sram_oe_n_in    output enable (active-low)
//   sram_we_n_in    write enable (active-low)
//   sram_ub_n_in    upper byte lane [15:8] enable (active-low)
//   sram_lb_n_in    lower byte lane [7:0] enable (active-low)
//   sram_addr_in    18-bit word address
//   sram_dq_in      write data from the controller
//   sram_dq_out     read data to the pad
//   sram_dq_oe_out  pad output enable (1 = responder drives dq)
//   oor_out         one-cycle pulse on an access above the implemented range
//   wr_count_out    committed writes since reset (wraps)
//   rd_count_out    read fetches since reset (wraps)
//   state_out       current FSM state (debug)
// ---------------------------------------------------------------------------
module sram_pin_responder #(
    parameter int DEPTH_W     = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sram_ce_n_in,
    input  logic        sram_oe_n_in,
    input  logic        sram_we_n_in,
    input  logic        sram_ub_n_in,
    input  logic        sram_lb_n_in,
    input  logic [17:0] sram_addr_in,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe_out,
    output logic        oor_out,
    output logic [15:0] wr_count_out,
    output logic [15:0] rd_count_out,
    output logic [2:0]  state_out
);

    // -----------------------------------------------------------------------
    // Types and constants
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_ACTIVE = 3'd1,
        ST_WR_COMMIT = 3'd2,
        ST_RD_FETCH  = 3'd3,
        ST_RD_DRIVE  = 3'd4
    } state_t;

    // Pin bundle layout: {ce_n, oe_n, we_n, ub_n, lb_n, addr[17:0], dq[15:0]}
    localparam int BUNDLE_W = 5 + 18 + 16;

    // Controls come out of reset inactive (high); address and data come out
    // as zero.
    localparam logic [BUNDLE_W-1:0] SYNC_RESET = {5'b11111, 18'd0, 16'd0};

    localparam int MEM_WORDS = 1 << DEPTH_W;

    // -----------------------------------------------------------------------
    // Input synchronizer
    //
    // All pins move through the chain as one bundle. Because of this, a
    // strobe edge and the address/data that go with it reach the FSM on the
    // same cycle.
    // -----------------------------------------------------------------------
    logic [BUNDLE_W-1:0] sync_q [SYNC_STAGES];
    logic [BUNDLE_W-1:0] pin_bundle;
    logic [BUNDLE_W-1:0] s_bundle;

    assign pin_bundle = {sram_ce_n_in, sram_oe_n_in, sram_we_n_in,
                         sram_ub_n_in, sram_lb_n_in, sram_addr_in, sram_dq_in};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RESET;
            end
        end else begin
            sync_q[0] <= pin_bundle;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_bundle = sync_q[SYNC_STAGES-1];

    logic        s_ce_n;
    logic        s_oe_n;
    logic        s_we_n;
    logic        s_ub_n;
    logic        s_lb_n;
    logic [17:0] s_addr;
    logic [15:0] s_dq;

    assign {s_ce_n, s_oe_n, s_we_n, s_ub_n, s_lb_n, s_addr, s_dq} = s_bundle;

    // An address is out of range when any bit above the implemented depth
    // is set.
    logic s_oor;
    assign s_oor = (s_addr >> DEPTH_W) != 18'd0;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t      state;
    state_t      next_state;

    logic [17:0] wr_addr_q;
    logic [15:0] wr_dq_q;
    logic        wr_ub_n_q;
    logic        wr_lb_n_q;
    logic [17:0] rd_addr_q;
    logic        ub_keep_q;
    logic        lb_keep_q;
    logic        dq_oe_q;
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    // FSM decode outputs
    logic wr_latch;
    logic wr_commit;
    logic rd_fetch;
    logic dq_oe_next;

    logic wr_oor;
    logic wr_any_lane;
    logic ram_we_lo;
    logic ram_we_hi;

    assign wr_oor      = (wr_addr_q >> DEPTH_W) != 18'd0;
    assign wr_any_lane = !wr_lb_n_q || !wr_ub_n_q;
    assign ram_we_lo   = wr_commit && !wr_oor && !wr_lb_n_q;
    assign ram_we_hi   = wr_commit && !wr_oor && !wr_ub_n_q;

    // -----------------------------------------------------------------------
    // Next-state / control decode
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        wr_latch   = 1'b0;
        wr_commit  = 1'b0;
        rd_fetch   = 1'b0;
        dq_oe_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!s_ce_n && !s_we_n) begin
                    next_state = ST_WR_ACTIVE;
                    wr_latch   = 1'b1;
                end else if (!s_ce_n && !s_oe_n) begin
                    next_state = ST_RD_FETCH;
                end
            end

            ST_WR_ACTIVE: begin
                // Keep tracking the pins while the strobe is low. The values
                // held when the strobe ends are the ones committed.
                if (s_we_n || s_ce_n) begin
                    next_state = ST_WR_COMMIT;
                end else begin
                    wr_latch = 1'b1;
                end
            end

            ST_WR_COMMIT: begin
                wr_commit  = 1'b1;
                next_state = ST_IDLE;
            end

            ST_RD_FETCH: begin
                rd_fetch   = 1'b1;
                dq_oe_next = 1'b1;
                next_state = ST_RD_DRIVE;
            end

            ST_RD_DRIVE: begin
                if (!s_ce_n && !s_we_n) begin
                    next_state = ST_WR_ACTIVE;
                    wr_latch   = 1'b1;
                end else if (s_ce_n || s_oe_n) begin
                    next_state = ST_IDLE;
                end else if (s_addr != rd_addr_q) begin
                    // Refetch without releasing the pad. The old word stays
                    // on dq until the new one arrives.
                    next_state = ST_RD_FETCH;
                    dq_oe_next = 1'b1;
                end else begin
                    dq_oe_next = 1'b1;
                end
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state, write latch, read lane latch, counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            wr_addr_q  <= 18'd0;
            wr_dq_q    <= 16'd0;
            wr_ub_n_q  <= 1'b1;
            wr_lb_n_q  <= 1'b1;
            rd_addr_q  <= 18'd0;
            ub_keep_q  <= 1'b0;
            lb_keep_q  <= 1'b0;
            dq_oe_q    <= 1'b0;
            wr_count_q <= 16'd0;
            rd_count_q <= 16'd0;
        end else begin
            state   <= next_state;
            dq_oe_q <= dq_oe_next;

            if (wr_latch) begin
                wr_addr_q <= s_addr;
                wr_dq_q   <= s_dq;
                wr_ub_n_q <= s_ub_n;
                wr_lb_n_q <= s_lb_n;
            end

            if (wr_commit && wr_any_lane && !wr_oor) begin
                wr_count_q <= wr_count_q + 16'd1;
            end

            if (rd_fetch) begin
                rd_addr_q  <= s_addr;
                // An out-of-range read clears both lanes, so it returns zero.
                ub_keep_q  <= !s_ub_n && !s_oor;
                lb_keep_q  <= !s_lb_n && !s_oor;
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Block RAM: byte-lane writes and a registered read. It has no reset,
    // so its contents survive rst_in. Reads and writes come from different
    // states and never collide.
    // -----------------------------------------------------------------------
    logic [15:0]        mem [MEM_WORDS];
    logic [15:0]        ram_q;
    logic [DEPTH_W-1:0] wr_idx;
    logic [DEPTH_W-1:0] rd_idx;

    assign wr_idx = wr_addr_q[DEPTH_W-1:0];
    assign rd_idx = s_addr[DEPTH_W-1:0];

    always_ff @(posedge clk_in) begin
        if (ram_we_lo) begin
            mem[wr_idx][7:0] <= wr_dq_q[7:0];
        end
        if (ram_we_hi) begin
            mem[wr_idx][15:8] <= wr_dq_q[15:8];
        end
        if (rd_fetch) begin
            ram_q <= mem[rd_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The lane-keep flags reset to 0. This masks the unreset RAM output, so
    // dq reads 0x0000 until the first fetch.
    assign sram_dq_out = ram_q & {{8{ub_keep_q}}, {8{lb_keep_q}}};

    // Gating with the sampled we_n releases the pad in the same cycle a
    // write strobe shows up, before the registered enable follows.
    assign sram_dq_oe_out = dq_oe_q && s_we_n;

    assign oor_out = ((state == ST_WR_COMMIT) && wr_oor) ||
                     ((state == ST_RD_FETCH)  && s_oor);

    assign wr_count_out = wr_count_q;
    assign rd_count_out = rd_count_q;
    assign state_out    = state;

endmodule
